// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the core load/store interface.
// Accepts one request at a time, waits LATENCY edges, then pulses rsp_valid
// for one cycle with RV32I byte/half/word sizing applied.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to make misaligned half/word
// accesses complete with rsp_err=1 and no write. Without it, the low address
// bits are forced to alignment and the access completes normally.
//
// state | meaning
// IDLE  | ready for a request, req_ready=1
// BUSY  | counting down access latency, access performed when counter hits 0
// RESP  | one-cycle response pulse, then back to IDLE
module dmem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          ready_q;

    logic          we_q;
    logic [2:0]    func3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          legal;
    logic          access_err;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic [31:0]   store_data;
    logic [3:0]    be;
    logic          access_now;
    logic          mem_we;

    // Address bits above the storage size are intentionally ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    // Ready is held low combinationally while reset is asserted.
    assign req_ready = ready_q && !rst;

    // Decode the latched request: legality, alignment, lane selection and extension.
    always_comb begin
        if (we_q)
            legal = (func3_q inside {3'b000, 3'b001, 3'b010});
        else
            legal = (func3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

        off = addr_q[1:0];
        if (func3_q[1:0] == 2'b01)
            off[0] = 1'b0;
        else if (func3_q[1:0] == 2'b10)
            off = 2'b00;

`ifdef DMEM_MISALIGN_TRAP_EN
        access_err = !legal
                   || ((func3_q[1:0] == 2'b01) && addr_q[0])
                   || ((func3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
        access_err = !legal;
`endif

        idx     = addr_q[AW+1:2];
        word    = mem[idx];
        shifted = word >> {off, 3'b000};

        case (func3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = word;
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase

        case (func3_q[1:0])
            2'b00: begin
                be         = 4'b0001 << off;
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << off;
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                store_data = wdata_q;
            end
        endcase

        access_now = (state == BUSY) && (count == '0) && !rst;
        mem_we     = access_now && we_q && !access_err;
    end

    // Storage with per-byte write enables; contents are never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k])
                    mem[idx][8*k +: 8] <= store_data[8*k +: 8];
            end
        end
    end

    // Control FSM: accept, latency countdown, single-cycle response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            ready_q   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        we_q    <= req_we;
                        func3_q <= req_func3;
                        addr_q  <= req_addr[AW+1:0];
                        wdata_q <= req_wdata;
                        count   <= CW'(LATENCY - 1);
                        ready_q <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= access_err;
                        rsp_rdata <= (we_q || access_err) ? 32'h0 : load_data;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    ready_q   <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
